// File: rtl/bus_scenario_sequencer.sv
// Table-driven scenario sequencer: walks a loadable step table and drives per-master bus controls.
// Optional WAIT watchdog (256 cycles) is built when SEQ_TIMEOUT_EN is defined.
module bus_scenario_sequencer #(
    parameter  int NUM_M     = 2,
    parameter  int DATA_W    = 8,
    parameter  int ADDR_W    = 14,
    parameter  int BURST_W   = 3,
    parameter  int DELAY_W   = 4,
    parameter  int DEPTH     = 32,
    parameter  int EN_CYCLES = 3,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int MF        = 2 + BURST_W + DATA_W + ADDR_W,
    localparam int ENTRY_W   = NUM_M * MF + DELAY_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [IDX_W-1:0]           start_idx,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_addr,
    input  logic [ENTRY_W-1:0]         cfg_wdata,
    input  logic [NUM_M-1:0]           m_request,
    output logic [NUM_M-1:0]           m_enable,
    output logic [NUM_M-1:0]           m_read_en,
    output logic [NUM_M*BURST_W-1:0]   m_burst_mode,
    output logic [NUM_M*DATA_W-1:0]    m_data,
    output logic [NUM_M*ADDR_W-1:0]    m_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [IDX_W-1:0]           cur_idx
);

    localparam int CNT_W = (DELAY_W > $clog2(EN_CYCLES) + 1) ? DELAY_W : $clog2(EN_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DELAY, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [ENTRY_W-1:0]     r_tbl [DEPTH];
    logic [ENTRY_W-1:0]     r_entry;
    logic [NUM_M*MF-1:0]    r_out;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_err;
    logic                   w_last;
    logic [DELAY_W-1:0]     w_delay;
    logic                   w_timeout;

    assign w_last  = r_entry[ENTRY_W-1];
    assign w_delay = r_entry[NUM_M*MF +: DELAY_W];

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_CYCLES = 256;
    localparam int TO_W      = $clog2(TO_CYCLES);
    logic [TO_W-1:0] r_to;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_to <= '0;
        else if (r_state != S_WAIT) r_to <= '0;
        else                       r_to <= r_to + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_DELAY;
            S_DELAY: if (r_cnt == CNT_W'(w_delay)) w_next = S_ISSUE;
            S_ISSUE: if (r_cnt == CNT_W'(EN_CYCLES - 1)) w_next = S_WAIT;
            S_WAIT: begin
                // Table end without a last marker terminates rather than wrapping to entry 0.
                if (m_request == '0)
                    w_next = (w_last || r_idx == IDX_W'(DEPTH - 1)) ? S_DONE : S_LOAD;
`ifdef SEQ_TIMEOUT_EN
                else if (r_to == TO_W'(TO_CYCLES - 1)) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end
`endif
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Table has no reset; writes are accepted only while idle so LOAD never races a write.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cfg_we) r_tbl[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_idx <= start_idx;
                    r_err <= 1'b0;
                end
                S_LOAD: begin
                    r_entry <= r_tbl[r_idx];
                    r_cnt   <= '0;
                end
                S_DELAY: begin
                    if (w_next == S_ISSUE) begin
                        r_out <= r_entry[NUM_M*MF-1:0];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ISSUE: r_cnt <= r_cnt + 1'b1;
                S_WAIT: begin
                    if (w_next == S_LOAD) r_idx <= r_idx + 1'b1;
                    if (w_next == S_DONE) begin
                        r_out <= '0;
                        if (w_timeout || !w_last) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Field values persist through WAIT and the next step's LOAD/DELAY; only enable is gated.
    for (genvar k = 0; k < NUM_M; k++) begin : g_m
        assign m_enable[k]                        = (r_state == S_ISSUE) & r_out[k*MF];
        assign m_read_en[k]                       = r_out[k*MF+1];
        assign m_burst_mode[k*BURST_W +: BURST_W] = r_out[k*MF+2 +: BURST_W];
        assign m_data[k*DATA_W +: DATA_W]         = r_out[k*MF+2+BURST_W +: DATA_W];
        assign m_addr[k*ADDR_W +: ADDR_W]         = r_out[k*MF+2+BURST_W+DATA_W +: ADDR_W];
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    assign cur_idx = r_idx;

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Randomized bench for bus_scenario_sequencer: a step-timeline model predicts every output each cycle.
module tb_bus_scenario_sequencer;
    localparam int NUM_M = 2, DATA_W = 8, ADDR_W = 14, BURST_W = 3, DELAY_W = 4;
    localparam int DEPTH = 32, EN_CYCLES = 3;
    localparam int IW = 5, MF = 27, EW = NUM_M * MF + DELAY_W + 1;

    logic                     clk = 1'b0, reset = 1'b0, start = 1'b0, cfg_we = 1'b0;
    logic [IW-1:0]            start_idx = '0, cfg_addr = '0;
    logic [EW-1:0]            cfg_wdata = '0;
    logic [NUM_M-1:0]         m_request = '0;
    logic [NUM_M-1:0]         m_enable, m_read_en;
    logic [NUM_M*BURST_W-1:0] m_burst_mode;
    logic [NUM_M*DATA_W-1:0]  m_data;
    logic [NUM_M*ADDR_W-1:0]  m_addr;
    logic                     busy, done, err;
    logic [IW-1:0]            cur_idx;

    bus_scenario_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .start_idx(start_idx),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en),
        .m_burst_mode(m_burst_mode), .m_data(m_data), .m_addr(m_addr),
        .busy(busy), .done(done), .err(err), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, req_hold = 0;
    bit chk_en = 1'b0;
    logic [EW-1:0]       mtbl [DEPTH];
    logic [NUM_M*MF-1:0] exp_f = '0;
    logic [1:0]          exp_en = '0;
    logic                exp_busy = 0, exp_done = 0, exp_err = 0;
    logic [IW-1:0]       exp_idx = '0;

    // monitor captures for the literal checks
    int start_cyc, first_en, en_cnt, both_cnt, rise1, chg, prev_idx, wlast;
    logic [13:0] cap_addr;
    logic [7:0]  cap_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [MF-1:0] mk(input bit en, input bit rd, input int bu, input int da, input int ad);
        logic [MF-1:0] f;
        f = {14'(ad), 8'(da), 3'(bu), rd, en};
        return f;
    endfunction

    function automatic logic [EW-1:0] ent(input logic [MF-1:0] m0, input logic [MF-1:0] m1,
                                          input int dly, input bit last);
        logic [EW-1:0] e;
        e = {last, 4'(dly), m1, m0};
        return e;
    endfunction

    task automatic wr(input int a, input logic [EW-1:0] d);
        cfg_we = 1; cfg_addr = 5'(a); cfg_wdata = d;
        tick();
        cfg_we = 0;
        mtbl[a] = d;
    endtask

    task automatic mon_clear();
        first_en = -1; en_cnt = 0; both_cnt = 0; rise1 = -1; chg = -1; prev_idx = 0;
        cap_addr = '0; cap_data = '0;
    endtask

    task automatic model_idle();
        exp_f = '0; exp_en = '0; exp_busy = 0; exp_done = 0;
    endtask

    // Request stimulus: held pattern when asked, otherwise mostly-idle random traffic.
    initial forever begin
        @(negedge clk);
        if (req_hold > 0) begin
            m_request = 2'b10;
            req_hold--;
        end else begin
            m_request = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
        end
    end

    logic [1:0]  e_rd;
    logic [5:0]  e_bu;
    logic [15:0] e_da;
    logic [27:0] e_ad;
    always @(negedge clk) if (chk_en) begin
        for (int k = 0; k < NUM_M; k++) begin
            e_rd[k]        = exp_f[k*MF+1];
            e_bu[k*3 +: 3] = exp_f[k*MF+2 +: 3];
            e_da[k*8 +: 8] = exp_f[k*MF+5 +: 8];
            e_ad[k*14+:14] = exp_f[k*MF+13 +: 14];
        end
        chk("m_enable", m_enable, exp_en);
        chk("m_read_en", m_read_en, e_rd);
        chk("m_burst_mode", m_burst_mode, e_bu);
        chk("m_data", m_data, e_da);
        chk("m_addr", m_addr, e_ad);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        chk("cur_idx", cur_idx, exp_idx);
    end

    always @(negedge clk) begin
        if (m_enable != 0) begin
            if (first_en < 0) begin
                first_en = cyc; cap_addr = m_addr[13:0]; cap_data = m_data[7:0];
            end
            en_cnt++;
            if (m_enable == 2'b11) both_cnt++;
        end
        if (m_enable[1] && rise1 < 0) rise1 = cyc;
        if (prev_idx == 4 && cur_idx == 5 && chg < 0) chg = cyc;
        prev_idx = int'(cur_idx);
    end

    // Step-timeline model: one LOAD cycle, delay+1 DELAY cycles, EN_CYCLES enabled cycles,
    // then WAIT until a sampled m_request of zero. Fields hold until DONE clears them.
    task automatic run(input int idx0, input bit inject, input int hold, input bit rst_issue);
        int idx, w;
        bit fin, inj;
        logic [EW-1:0] e;
        inj = inject;
        start_idx = 5'(idx0); start = 1;
        tick();
        start = 0; start_cyc = cyc;
        idx = idx0; exp_busy = 1; exp_idx = 5'(idx); exp_err = 0;
        fin = 0;
        while (!fin) begin
            e = mtbl[idx];
            tick();
            repeat (int'(e[NUM_M*MF +: DELAY_W])) tick();
            tick();
            exp_f  = e[NUM_M*MF-1:0];
            exp_en = {e[MF], e[0]};
            if (rst_issue) begin
                #2 reset = 0;
                model_idle(); exp_err = 0; exp_idx = '0;
                #1;
                chk("rst_enable", m_enable, 2'b00);
                chk("rst_busy", busy, 1'b0);
                chk("rst_addr", m_addr, 28'd0);
                @(posedge clk); #1 reset = 1;
                return;
            end
            repeat (EN_CYCLES - 1) tick();
            tick();
            exp_en = '0;
            if (hold > 0) req_hold = hold;
            if (inj) begin
                start = 1; start_idx = 5'($urandom); cfg_we = 1; cfg_addr = '0; cfg_wdata = '1;
            end
            w = 0;
            do begin
                tick(); w++;
                if (inj) begin start = 0; cfg_we = 0; inj = 0; end
            end while (m_request != 0 && w < 3000);
            if (m_request != 0) begin
                total++; bad++;
                $display("FAIL wait_bound actual=%0d required<3000", w);
                reset = 0; model_idle(); exp_err = 0; exp_idx = '0; req_hold = 0;
                tick(); reset = 1;
                return;
            end
            wlast = w;
            if (e[EW-1] || idx == DEPTH - 1) begin
                exp_err  = !e[EW-1];
                exp_done = 1; exp_f = '0;
                tick();
                exp_done = 0; exp_busy = 0;
                fin = 1;
            end else begin
                idx++;
                exp_idx = 5'(idx);
            end
        end
    endtask

    initial begin
        #22;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_enable", m_enable, 2'b00);
        chk("reset_idx", cur_idx, 5'd0);
        chk("reset_data", m_data, 16'd0);
        @(posedge clk); #1 reset = 1;
        chk_en = 1;
        for (int i = 0; i < DEPTH; i++)
            wr(i, ent(27'($urandom), 27'($urandom), int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0));

        // single write, latency 2 and 3-cycle enable window
        wr(0, ent(mk(1, 0, 0, 8'hAA, 1365), '0, 0, 1));
        mon_clear(); run(0, 0, 0, 0);
        chk("t1_latency", first_en - start_cyc, 2);
        chk("t1_en_cycles", en_cnt, 3);
        chk("t1_addr", cap_addr, 14'd1365);
        chk("t1_data", cap_data, 8'hAA);
        chk("t1_err", err, 1'b0);

        // dual-master step
        wr(1, ent(mk(1, 1, 0, 0, 111), mk(1, 0, 1, 8'h30, 1365), 0, 1));
        mon_clear(); run(1, 0, 0, 0);
        chk("t2_both", both_cnt, 3);
        chk("t2_any", en_cnt, 3);

        // chained split, m1 rises 10 cycles after entry4 WAIT exit
        wr(4, ent(mk(1, 1, 0, 0, 5097), '0, 0, 0));
        wr(5, ent('0, mk(1, 0, 0, 62, 1001), 8, 1));
        mon_clear(); run(4, 0, 0, 0);
        chk("t3_rise_gap", rise1 - chg, 10);
        chk("t3_idx", cur_idx, 5'd5);

        // table end without last
        wr(31, ent(mk(0, 1, 2, 3, 4), mk(1, 0, 5, 6, 7), 1, 0));
        run(31, 0, 0, 0);
        chk("t4_err", err, 1'b1);
        chk("t4_idx", cur_idx, 5'd31);

        // held request plus start/cfg_we while busy
        wr(7, ent('0, mk(1, 1, 4, 8'h5A, 2000), 2, 1));
        run(7, 1, 20, 0);
        chk("t5_hold", wlast >= 21, 1'b1);
        mon_clear(); run(0, 0, 0, 0);
        chk("t6_tbl_kept", cap_addr, 14'd1365);

        // reset mid-ISSUE then recovery
        run(1, 0, 0, 1);
        repeat (4) tick();
        mon_clear(); run(0, 0, 0, 0);
        chk("t6_recover", cap_data, 8'hAA);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                wr(int'($urandom_range(0, 31)),
                   ent(27'($urandom), 27'($urandom), int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0));
            run(int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0, 0, 0);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
